// File: rtl/branch_resolve_predict.sv
// ---------------------------------------------------------------------------
// branch_resolve_predict
//
// Resolves the six RV32I conditional branches from ALU flags. Keeps a
// direct-mapped table of 2-bit saturating counters that predicts
// taken/not-taken at fetch. Compares each resolved outcome with the
// prediction carried down the pipe, and raises a registered one-cycle flush
// on a mismatch.
//
// Parameters
//   INDEX_BITS  log2 of table entries (2^INDEX_BITS counters)
//   PC_WIDTH    PC width; table index = pc[INDEX_BITS+1:2]
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_pc          fetch-stage PC used for lookup
//   predict_taken     combinational prediction (counter MSB)
//   resolve_valid     execute-stage instruction valid
//   Branch            decoded conditional branch
//   func3             branch funct3
//   zero/negative/borrow  ALU compare flags
//   resolve_pc        PC of the resolving branch
//   resolve_pred      prediction captured at fetch
//   branch_result     combinational actual-taken
//   mispredict        combinational prediction mismatch
//   flush             registered one-cycle copy of mispredict
//
// Optional feature macro: BRP_STATS_EN adds 16-bit saturating
// stat_branches / stat_mispredicts outputs.
// ---------------------------------------------------------------------------
module branch_resolve_predict #(
   parameter int INDEX_BITS = 4,
   parameter int PC_WIDTH   = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   output logic                predict_taken,
   input  logic                resolve_valid,
   input  logic                Branch,
   input  logic [2:0]          func3,
   input  logic                zero,
   input  logic                negative,
   input  logic                borrow,
   input  logic [PC_WIDTH-1:0] resolve_pc,
   input  logic                resolve_pred,
   output logic                branch_result,
   output logic                mispredict,
`ifdef BRP_STATS_EN
   output logic [15:0]         stat_branches,
   output logic [15:0]         stat_mispredicts,
`endif
   output logic                flush
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            r_table [ENTRIES];
   logic                  r_flush;
   logic [INDEX_BITS-1:0] w_fetchIdx;
   logic [INDEX_BITS-1:0] w_resIdx;
   logic                  w_cond;
   logic                  w_legal;
   logic                  w_resEn;
   logic                  w_unused;

   assign w_fetchIdx = fetch_pc[INDEX_BITS+1:2];
   assign w_resIdx   = resolve_pc[INDEX_BITS+1:2];

   // PC bits outside the index field are deliberately ignored: there are no
   // tags, so aliasing PCs share a counter.
   assign w_unused = ^{fetch_pc[PC_WIDTH-1:INDEX_BITS+2], fetch_pc[1:0],
                       resolve_pc[PC_WIDTH-1:INDEX_BITS+2], resolve_pc[1:0]};

   // Branch condition decode. Codes 010 and 011 are not branches and are
   // flagged illegal so they neither resolve taken nor train the table.
   always_comb begin
      w_cond  = 1'b0;
      w_legal = 1'b1;
      case (func3)
         3'b000:  w_cond = zero;
         3'b001:  w_cond = ~zero;
         3'b100:  w_cond = negative;
         3'b101:  w_cond = ~negative;
         3'b110:  w_cond = borrow;
         3'b111:  w_cond = ~borrow;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_resEn       = resolve_valid & Branch & w_legal;
   assign branch_result = w_resEn & w_cond;
   assign mispredict    = w_resEn & (branch_result != resolve_pred);

   // Lookup reads the stored counter directly; a same-cycle update to the
   // same entry only becomes visible after the edge.
   assign predict_taken = r_table[w_fetchIdx][1];

   // Counter table: reset to weak not-taken, then trained by every
   // qualified resolve with saturating increment/decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_table[i] <= 2'b01;
         end
      end else if (w_resEn) begin
         if (branch_result) begin
            if (r_table[w_resIdx] != 2'b11) begin
               r_table[w_resIdx] <= r_table[w_resIdx] + 2'd1;
            end
         end else begin
            if (r_table[w_resIdx] != 2'b00) begin
               r_table[w_resIdx] <= r_table[w_resIdx] - 2'd1;
            end
         end
      end
   end

   // Flush is the mispredict delayed by one edge so the front end gets a
   // clean registered redirect pulse; reset drops any pending flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush <= 1'b0;
      end else begin
         r_flush <= mispredict;
      end
   end

   assign flush = r_flush;

`ifdef BRP_STATS_EN
   logic [15:0] r_statBranches;
   logic [15:0] r_statMispredicts;

   // Saturating statistics: they hold at all-ones rather than wrapping so a
   // long run never reports a misleadingly small count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_statBranches    <= 16'h0000;
         r_statMispredicts <= 16'h0000;
      end else if (w_resEn) begin
         if (r_statBranches != 16'hFFFF) begin
            r_statBranches <= r_statBranches + 16'd1;
         end
         if (mispredict && (r_statMispredicts != 16'hFFFF)) begin
            r_statMispredicts <= r_statMispredicts + 16'd1;
         end
      end
   end

   assign stat_branches    = r_statBranches;
   assign stat_mispredicts = r_statMispredicts;
`endif

endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised branch resolution and prediction unit for the pipelined RISC-V core. It resolves all six RV32I conditional branches from ALU flags and keeps a direct-mapped table of 2-bit saturating counters that predicts taken/not-taken at fetch. It compares each resolved outcome with the prediction carried down the pipe and raises a registered one-cycle flush on a mismatch. It replaces the single-cycle BEQ/BNE/BLT/BGE resolver in the execute stage.

## Interface
- INDEX_BITS, 4: log2 of table entries; 2^INDEX_BITS counters.
- PC_WIDTH, 32: PC width; index = pc[INDEX_BITS+1:2].
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_pc  in  PC_WIDTH  fetch-stage PC used for lookup.
- predict_taken  out  1  combinational; MSB of counter[fetch_pc index].
- resolve_valid  in  1  execute-stage instruction is valid.
- Branch  in  1  decoded conditional-branch instruction.
- func3  in  3  branch funct3.
- zero  in  1  ALU result zero (rs1 == rs2).
- negative  in  1  signed rs1 < rs2, overflow-corrected by the ALU.
- borrow  in  1  unsigned rs1 < rs2.
- resolve_pc  in  PC_WIDTH  PC of the resolving branch.
- resolve_pred  in  1  predict_taken value captured at fetch for this branch.
- branch_result  out  1  combinational actual-taken.
- mispredict  out  1  combinational; `res_en & (branch_result != resolve_pred)`.
- flush  out  1  registered copy of mispredict; one-cycle pulse.

## Operation
- res_en = resolve_valid & Branch & legal func3.
- Decode:
  - 000 BEQ: zero.
  - 001 BNE: ~zero.
  - 100 BLT: negative.
  - 101 BGE: ~negative.
  - 110 BLTU: borrow.
  - 111 BGEU: ~borrow.
  - 010 and 011 are illegal: branch_result = 0, res_en = 0, no table update.
- branch_result = res_en & decoded condition.
- Table update, on a clock edge with res_en = 1, at index(resolve_pc):
  - taken: counter increments and saturates at 11.
  - not taken: counter decrements and saturates at 00.
- Counter states:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Prediction is the MSB of the counter.
- Lookup and update on the same index in the same cycle: predict_taken shows the pre-update value, with no bypass. The new value is visible the next cycle.
- Aliasing is permitted and there are no tags; PCs that share an index share a counter.

## Timing
- Reset (rst_n low, asynchronous):
  - every counter is set to 01.
  - flush = 0.
  - statistics counters, when compiled in, are set to 0.
  - Combinational outputs follow their inputs, so predict_taken = 0 after reset.
- Reset asserted mid-operation: all state clears immediately, and any pending flush is dropped.
- Lookup latency is 0 cycles; resolution latency is 0 cycles.
- Update latency is 1 edge.
- flush is asserted for exactly the cycle after a mispredict. Back-to-back mispredicts give back-to-back flush cycles.
- Inputs must be stable before the edge. There is no handshake: res_en qualifies every resolve-side input.

## Configuration
- BRP_STATS_EN defined: adds outputs `stat_branches` and `stat_mispredicts`, both 16 bits.
  - Each increments on a clock edge when res_en is 1 (and, for stat_mispredicts, when mispredict is 1).
  - Each saturates at 16'hFFFF and clears on reset.
- BRP_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then fetch_pc = 0x40: predict_taken = 0 and flush = 0. Resolve BEQ at 0x40 with zero = 1 and resolve_pred = 0: branch_result = 1, mispredict = 1, flush = 1 next cycle, counter = 10, predict_taken = 1 from the next cycle.
- Four taken resolves at the same PC: the counter saturates at 11. One not-taken resolve gives 10, so the prediction is still taken. A second not-taken gives 01, so the prediction becomes not-taken.
- Sweep func3 over all 8 codes with zero, negative and borrow in every combination: branch_result matches the decode list. func3 010 and 011 give 0 with no counter change and no flush.
- Same index resolved and fetched in the same cycle, counter 01 and taken: predict_taken = 0 that cycle and 1 the next.
- Drive rst_n low between clock edges while flush = 1: flush drops immediately, and all counters read 01 afterwards.
- With BRP_STATS_EN: 70000 resolves, 3 of them mispredicted: stat_branches = 16'hFFFF and stat_mispredicts = 3.
